layer_motion: RTL

// Per-frame sprite motion controller that sits directly upstream of a layer instance.

---
 rtl/layer_motion.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/layer_motion.sv
// layer_motion: per-frame sprite motion controller feeding a layer instance.
// Each sprite copy has a shadow position, velocity and flip state. Game logic
// writes only the shadow copy. Once per frame, during vertical blanking, every
// copy is advanced and bounced off the screen edges. The results are then
// committed to the offset/flip outputs in one cycle, so those outputs stay
// stable for the whole active frame.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   hdata, vdata          beam column/row; (vdata==VSIZE && hdata==0) starts a frame tick
//   pause                 1 = leave positions unchanged at the frame update
//   cmd_valid/cmd_ready   command handshake; op 0 = load position, op 1 = load velocity
//   cmd_op, cmd_idx       command type and target replica (idx >= REPLICAS is dropped)
//   cmd_h, cmd_v          position, or velocity in the low SWIDTH bits
//   hoffset, voffset      committed offsets, one per replica
//   hflip, vflip          committed flips, one per replica
//   busy                  controller is not idle
//   overrun               sticky, set by a frame tick that arrives while busy
//   frame_cnt             number of commits, wraps at 0xFFFF
//
// state  | meaning
// IDLE   | waiting for a frame tick; commands are accepted here
// UPDATE | advancing replica upd_idx, one replica per cycle
// COMMIT | copying shadow state to the outputs, counting the frame
module layer_motion #(
    parameter int HWIDTH   = 12,
    parameter int VWIDTH   = 12,
    parameter int HSIZE    = 640,
    parameter int VSIZE    = 480,
    parameter int REPLICAS = 1,
    parameter int SPR_W    = 32,
    parameter int SPR_H    = 32,
    parameter int SWIDTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [HWIDTH-1:0]             hdata,
    input  logic [VWIDTH-1:0]             vdata,
    input  logic                          pause,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_op,
    input  logic [$clog2(REPLICAS):0]     cmd_idx,
    input  logic [HWIDTH-1:0]             cmd_h,
    input  logic [VWIDTH-1:0]             cmd_v,
    output logic [HWIDTH-1:0]             hoffset [REPLICAS],
    output logic [VWIDTH-1:0]             voffset [REPLICAS],
    output logic                          hflip [REPLICAS],
    output logic                          vflip [REPLICAS],
    output logic                          busy,
    output logic                          overrun,
    output logic [15:0]                   frame_cnt
);
    localparam int IDXW = $clog2(REPLICAS) + 1;
    localparam logic signed [HWIDTH:0] HLIM   = (HWIDTH+1)'(HSIZE - SPR_W);
    localparam logic signed [VWIDTH:0] VLIM   = (VWIDTH+1)'(VSIZE - SPR_H);
    localparam logic [HWIDTH-1:0]      HLIM_U = HWIDTH'(HSIZE - SPR_W);
    localparam logic [VWIDTH-1:0]      VLIM_U = VWIDTH'(VSIZE - SPR_H);
    localparam logic [SWIDTH-1:0]      VEL_MIN = {1'b1, {(SWIDTH-1){1'b0}}};
    localparam logic [SWIDTH-1:0]      VEL_MAX = {1'b0, {(SWIDTH-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, UPDATE, COMMIT} state_t;

    state_t            state, state_next;
    logic [IDXW-1:0]   upd_idx;
    logic              tick_q, tick_q2, tick, cmd_fire;

    logic [HWIDTH-1:0] hpos   [REPLICAS];
    logic [VWIDTH-1:0] vpos   [REPLICAS];
    logic [SWIDTH-1:0] hvel   [REPLICAS];
    logic [SWIDTH-1:0] vvel   [REPLICAS];
    logic              hflip_s[REPLICAS];
    logic              vflip_s[REPLICAS];

    logic [HWIDTH-1:0] cur_hpos, new_hpos;
    logic [VWIDTH-1:0] cur_vpos, new_vpos;
    logic [SWIDTH-1:0] cur_hvel, cur_vvel, new_hvel, new_vvel;
    logic              cur_hflip, cur_vflip, new_hflip, new_vflip;
    logic signed [HWIDTH:0] h_next;
    logic signed [VWIDTH:0] v_next;

    // The most negative velocity has no positive twin; clamp it instead of wrapping.
    function automatic logic [SWIDTH-1:0] neg_sat(input logic [SWIDTH-1:0] v);
        return (v == VEL_MIN) ? VEL_MAX : -v;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q  <= 1'b0;
            tick_q2 <= 1'b0;
        end else begin
            tick_q  <= (vdata == VWIDTH'(VSIZE)) && (hdata == '0);
            tick_q2 <= tick_q;
        end
    end

    assign tick      = tick_q & ~tick_q2;
    assign cmd_ready = rst_n && (state == IDLE) && !tick;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign busy      = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (tick) state_next = UPDATE;
            UPDATE:  if (upd_idx == IDXW'(REPLICAS - 1)) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            upd_idx <= '0;
        end else begin
            state   <= state_next;
            upd_idx <= (state == UPDATE) ? upd_idx + IDXW'(1) : '0;
        end
    end

    always_comb begin
        cur_hpos  = '0;
        cur_vpos  = '0;
        cur_hvel  = '0;
        cur_vvel  = '0;
        cur_hflip = 1'b0;
        cur_vflip = 1'b0;
        for (int r = 0; r < REPLICAS; r++) begin
            if (upd_idx == IDXW'(r)) begin
                cur_hpos  = hpos[r];
                cur_vpos  = vpos[r];
                cur_hvel  = hvel[r];
                cur_vvel  = vvel[r];
                cur_hflip = hflip_s[r];
                cur_vflip = vflip_s[r];
            end
        end
    end

    // One extra bit so both overshoot directions are visible as signed values.
    always_comb begin
        h_next    = $signed({1'b0, cur_hpos}) +
                    $signed({{(HWIDTH+1-SWIDTH){cur_hvel[SWIDTH-1]}}, cur_hvel});
        new_hpos  = h_next[HWIDTH-1:0];
        new_hvel  = cur_hvel;
        new_hflip = cur_hflip;
        if (h_next > HLIM) begin
            new_hpos  = HLIM_U;
            new_hvel  = neg_sat(cur_hvel);
            new_hflip = ~cur_hflip;
        end else if (h_next[HWIDTH]) begin
            new_hpos  = '0;
            new_hvel  = neg_sat(cur_hvel);
            new_hflip = ~cur_hflip;
        end

        v_next    = $signed({1'b0, cur_vpos}) +
                    $signed({{(VWIDTH+1-SWIDTH){cur_vvel[SWIDTH-1]}}, cur_vvel});
        new_vpos  = v_next[VWIDTH-1:0];
        new_vvel  = cur_vvel;
        new_vflip = cur_vflip;
        if (v_next > VLIM) begin
            new_vpos  = VLIM_U;
            new_vvel  = neg_sat(cur_vvel);
            new_vflip = ~cur_vflip;
        end else if (v_next[VWIDTH]) begin
            new_vpos  = '0;
            new_vvel  = neg_sat(cur_vvel);
            new_vflip = ~cur_vflip;
        end
    end

    // Commands only land in IDLE and updates only in UPDATE, so they never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < REPLICAS; r++) begin
                hpos[r]    <= '0;
                vpos[r]    <= '0;
                hvel[r]    <= '0;
                vvel[r]    <= '0;
                hflip_s[r] <= 1'b0;
                vflip_s[r] <= 1'b0;
            end
        end else begin
            for (int r = 0; r < REPLICAS; r++) begin
                if (cmd_fire && cmd_idx == IDXW'(r)) begin
                    if (!cmd_op) begin
                        hpos[r] <= cmd_h;
                        vpos[r] <= cmd_v;
                    end else begin
                        hvel[r] <= cmd_h[SWIDTH-1:0];
                        vvel[r] <= cmd_v[SWIDTH-1:0];
                        if (cmd_h[SWIDTH-1:0] != '0) hflip_s[r] <= cmd_h[SWIDTH-1];
                        if (cmd_v[SWIDTH-1:0] != '0) vflip_s[r] <= cmd_v[SWIDTH-1];
                    end
                end
                if (state == UPDATE && !pause && upd_idx == IDXW'(r)) begin
                    hpos[r]    <= new_hpos;
                    vpos[r]    <= new_vpos;
                    hvel[r]    <= new_hvel;
                    vvel[r]    <= new_vvel;
                    hflip_s[r] <= new_hflip;
                    vflip_s[r] <= new_vflip;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < REPLICAS; r++) begin
                hoffset[r] <= '0;
                voffset[r] <= '0;
                hflip[r]   <= 1'b0;
                vflip[r]   <= 1'b0;
            end
            frame_cnt <= '0;
            overrun   <= 1'b0;
        end else begin
            if (state == COMMIT) begin
                for (int r = 0; r < REPLICAS; r++) begin
                    hoffset[r] <= hpos[r];
                    voffset[r] <= vpos[r];
                    hflip[r]   <= hflip_s[r];
                    vflip[r]   <= vflip_s[r];
                end
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (tick && state != IDLE) overrun <= 1'b1;
        end
    end
endmodule
